// File: rtl/ca_sweep_sequencer.sv
// Cell-update sequencer for the cellular-automaton cell RAM.
// Walks every cell once per sweep, issuing one strobe per phase.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   run                        level: keep sweeping while high
//   step                       pulse: one full sweep when idle and run=0
//   slow                       select SLOW_DIV cycles per phase
//   read_addr, write_addr      cell RAM read / RAM+VRAM write address
//   shift_en, rule_en,
//   write_en, addr_en          one-cycle phase strobes
//   busy                       sequencer is not idle
//   sweep_done                 pulse when write_addr wraps to 0
//   generation                 completed sweep count
module ca_sweep_sequencer #(
    parameter int WIDTH    = 160,
    parameter int HEIGHT   = 120,
    parameter int ADDR_W   = 20,
    parameter int FAST_DIV = 2,
    parameter int SLOW_DIV = 512,
    parameter int GEN_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    input  logic              slow,
    output logic [ADDR_W-1:0] read_addr,
    output logic [ADDR_W-1:0] write_addr,
    output logic              shift_en,
    output logic              rule_en,
    output logic              write_en,
    output logic              addr_en,
    output logic              busy,
    output logic              sweep_done,
    output logic [GEN_W-1:0]  generation
);

    localparam int VRAM_SIZE = WIDTH * HEIGHT;
    localparam int MAX_DIV   = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int CNT_W     = $clog2(MAX_DIV);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VRAM_SIZE - 1);
    localparam logic [ADDR_W-1:0] RD_INIT   = ADDR_W'(WIDTH + 1);
    localparam logic [CNT_W-1:0]  FAST_TOP  = CNT_W'(FAST_DIV - 1);
    localparam logic [CNT_W-1:0]  SLOW_TOP  = CNT_W'(SLOW_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        RULE,
        WRITE,
        ADDR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   top_q, top_d;
    logic               single_q, single_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [ADDR_W-1:0]  raddr_q, raddr_d;
    logic [GEN_W-1:0]   gen_q, gen_d;

    logic               phase_end;
    logic               first_cyc;
    logic               wrap;
    logic [CNT_W-1:0]   top_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            top_q    <= FAST_TOP;
            single_q <= 1'b0;
            waddr_q  <= '0;
            raddr_q  <= RD_INIT;
            gen_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            top_q    <= top_d;
            single_q <= single_d;
            waddr_q  <= waddr_d;
            raddr_q  <= raddr_d;
            gen_q    <= gen_d;
        end
    end

    // Phase length is latched on phase entry, so slow only takes
    // effect at the next phase boundary.
    assign top_sel   = slow ? SLOW_TOP : FAST_TOP;
    assign first_cyc = (cnt_q == '0);
    assign phase_end = (state_q != IDLE) && (cnt_q == top_q);

    assign shift_en   = (state_q == SHIFT) && first_cyc;
    assign rule_en    = (state_q == RULE)  && first_cyc;
    assign write_en   = (state_q == WRITE) && first_cyc;
    assign addr_en    = (state_q == ADDR)  && first_cyc;
    assign busy       = (state_q != IDLE);
    assign wrap       = addr_en && (waddr_q == LAST_ADDR);
    assign sweep_done = wrap;

    assign read_addr  = raddr_q;
    assign write_addr = waddr_q;
    assign generation = gen_q;

    // Address advance; read_addr tracks write_addr + WIDTH + 1
    // modulo the RAM size.
    always_comb begin
        waddr_d = waddr_q;
        raddr_d = raddr_q;
        gen_d   = gen_q;
        if (addr_en) begin
            if (wrap) begin
                waddr_d = '0;
                raddr_d = RD_INIT;
                gen_d   = gen_q + GEN_W'(1);
            end else begin
                waddr_d = waddr_q + ADDR_W'(1);
                if (raddr_q == LAST_ADDR) begin
                    raddr_d = '0;
                end else begin
                    raddr_d = raddr_q + ADDR_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        top_d    = top_q;
        single_d = single_q;

        if (busy) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (phase_end) begin
            cnt_d = '0;
            top_d = top_sel;
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (run) begin
                    state_d  = SHIFT;
                    single_d = 1'b0;
                    top_d    = top_sel;
                end else if (step) begin
                    state_d  = SHIFT;
                    single_d = 1'b1;
                    top_d    = top_sel;
                end
            end
            SHIFT: begin
                if (phase_end) state_d = RULE;
            end
            RULE: begin
                if (phase_end) state_d = WRITE;
            end
            WRITE: begin
                if (phase_end) state_d = ADDR;
            end
            ADDR: begin
                // The advance already happened on the strobe cycle,
                // so write_addr==0 here means this cell wrapped.
                if (phase_end) begin
                    if (run) begin
                        state_d = SHIFT;
                    end else if (single_q && (waddr_q != '0)) begin
                        state_d = SHIFT;
                    end else begin
                        state_d  = IDLE;
                        single_d = 1'b0;
                        cnt_d    = '0;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                single_d = 1'b0;
                cnt_d    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ca_sweep_sequencer.sv
// Self-checking bench for ca_sweep_sequencer on a reduced 10x6 grid.
// Table-driven first cell trace plus hand-written corner sequences.
module tb_ca_sweep_sequencer;

    localparam int W  = 10;
    localparam int H  = 6;
    localparam int AW = 20;
    localparam int GW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic          step;
    logic          slow;
    logic [AW-1:0] read_addr;
    logic [AW-1:0] write_addr;
    logic          shift_en;
    logic          rule_en;
    logic          write_en;
    logic          addr_en;
    logic          busy;
    logic          sweep_done;
    logic [GW-1:0] generation;

    ca_sweep_sequencer #(
        .WIDTH    (W),
        .HEIGHT   (H),
        .ADDR_W   (AW),
        .FAST_DIV (2),
        .SLOW_DIV (16),
        .GEN_W    (GW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .step       (step),
        .slow       (slow),
        .read_addr  (read_addr),
        .write_addr (write_addr),
        .shift_en   (shift_en),
        .rule_en    (rule_en),
        .write_en   (write_en),
        .addr_en    (addr_en),
        .busy       (busy),
        .sweep_done (sweep_done),
        .generation (generation)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int outs();
        return int'({shift_en, rule_en, write_en, addr_en, busy, sweep_done});
    endfunction

    typedef struct {
        logic       run;
        logic [5:0] o;
        int         wa;
        int         ra;
    } vec_t;

    vec_t vt[10];

    initial begin
        int n;
        int wc;
        int ac;
        int dc;
        int found;

        // {shift, rule, write, addr, busy, done}
        vt[0] = '{1'b1, 6'b100010, 0, 11};
        vt[1] = '{1'b1, 6'b000010, 0, 11};
        vt[2] = '{1'b1, 6'b010010, 0, 11};
        vt[3] = '{1'b1, 6'b000010, 0, 11};
        vt[4] = '{1'b1, 6'b001010, 0, 11};
        vt[5] = '{1'b1, 6'b000010, 0, 11};
        vt[6] = '{1'b1, 6'b000110, 0, 11};
        vt[7] = '{1'b0, 6'b000010, 1, 12};
        vt[8] = '{1'b0, 6'b000000, 1, 12};
        vt[9] = '{1'b0, 6'b000000, 1, 12};

        reset = 1'b1;
        run   = 1'b0;
        step  = 1'b0;
        slow  = 1'b0;
        repeat (2) tick();
        chk("rst_outs", outs(), 0);
        chk("rst_waddr", int'(write_addr), 0);
        chk("rst_raddr", int'(read_addr), 11);
        chk("rst_gen", int'(generation), 0);
        reset = 1'b0;
        tick();
        chk("idle_outs", outs(), 0);

        for (int i = 0; i < 10; i++) begin
            run = vt[i].run;
            tick();
            chk($sformatf("vec%0d_outs", i), outs(), int'(vt[i].o));
            chk($sformatf("vec%0d_waddr", i), int'(write_addr), vt[i].wa);
            chk($sformatf("vec%0d_raddr", i), int'(read_addr), vt[i].ra);
        end

        // Run dropped during RULE of cell 5: cell completes, then idle.
        run = 1'b1;
        found = 0;
        for (n = 0; n < 200; n++) begin
            tick();
            if (rule_en && write_addr == 5) begin
                found = 1;
                break;
            end
        end
        chk("reach_rule5", found, 1);
        run = 1'b0;
        wc = 0;
        ac = 0;
        for (n = 0; n < 50; n++) begin
            tick();
            if (write_en) wc++;
            if (addr_en) ac++;
            if (!busy) break;
        end
        chk("drop_write_cnt", wc, 1);
        chk("drop_addr_cnt", ac, 1);
        chk("drop_busy", int'(busy), 0);
        chk("drop_waddr", int'(write_addr), 6);
        chk("drop_raddr", int'(read_addr), 17);
        run = 1'b1;
        found = 0;
        for (n = 0; n < 50; n++) begin
            tick();
            if (write_en) begin
                found = 1;
                break;
            end
        end
        chk("resume_write_seen", found, 1);
        chk("resume_waddr", int'(write_addr), 6);

        // Slow raised during a SHIFT strobe: that phase stays fast.
        found = 0;
        for (n = 0; n < 50; n++) begin
            tick();
            if (shift_en) begin
                found = 1;
                break;
            end
        end
        chk("slow_shift_seen", found, 1);
        slow = 1'b1;
        n = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            n++;
            if (shift_en) break;
        end
        chk("slow_cell1_len", n, 2 + 3 * 16);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            n++;
            if (shift_en) break;
        end
        chk("slow_cell2_len", n, 64);
        slow = 1'b0;

        // Wrap of read_addr and write_addr.
        found = 0;
        for (n = 0; n < 2000; n++) begin
            tick();
            if (addr_en && write_addr == 48) begin
                found = 1;
                break;
            end
        end
        chk("wrap48_seen", found, 1);
        chk("wrap48_raddr", int'(read_addr), 59);
        chk("wrap48_done", int'(sweep_done), 0);
        tick();
        chk("wrap49_waddr", int'(write_addr), 49);
        chk("wrap49_raddr", int'(read_addr), 0);
        found = 0;
        for (n = 0; n < 200; n++) begin
            tick();
            if (addr_en && write_addr == 59) begin
                found = 1;
                break;
            end
        end
        chk("wrap59_seen", found, 1);
        chk("wrap59_done", int'(sweep_done), 1);
        chk("wrap59_gen", int'(generation), 0);
        tick();
        chk("wrap0_waddr", int'(write_addr), 0);
        chk("wrap0_raddr", int'(read_addr), 11);
        chk("wrap0_gen", int'(generation), 1);
        chk("wrap0_done", int'(sweep_done), 0);

        // Asynchronous reset while write_en is high.
        found = 0;
        for (n = 0; n < 100; n++) begin
            tick();
            if (write_en && write_addr == 1) begin
                found = 1;
                break;
            end
        end
        chk("arst_write_seen", found, 1);
        reset = 1'b1;
        #1;
        chk("arst_outs", outs(), 0);
        chk("arst_waddr", int'(write_addr), 0);
        chk("arst_raddr", int'(read_addr), 11);
        chk("arst_gen", int'(generation), 0);
        run = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // Single sweep from address 0, with a step pulse while busy.
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("step_busy", int'(busy), 1);
        wc = 0;
        dc = 0;
        for (n = 0; n < 1000; n++) begin
            tick();
            if (write_en) wc++;
            if (sweep_done) dc++;
            step = (n == 100);
            if (!busy) break;
        end
        step = 1'b0;
        chk("step_writes", wc, 60);
        chk("step_dones", dc, 1);
        chk("step_waddr", int'(write_addr), 0);
        chk("step_gen", int'(generation), 1);
        chk("step_busy_end", int'(busy), 0);
        repeat (20) tick();
        chk("step_not_queued", int'(busy), 0);

        // Step and run together: free-run; generation wraps mod 8.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        run  = 1'b1;
        step = 1'b1;
        tick();
        step = 1'b0;
        dc = 0;
        for (n = 0; n < 6000; n++) begin
            tick();
            if (sweep_done) dc++;
            if (dc == 9) break;
        end
        chk("free_sweeps", dc, 9);
        tick();
        chk("free_gen", int'(generation), 1);
        found = 0;
        for (n = 0; n < 20; n++) begin
            tick();
            if (addr_en) begin
                found = 1;
                break;
            end
        end
        chk("free_addr_seen", found, 1);
        run = 1'b0;
        for (n = 0; n < 30; n++) begin
            tick();
            if (!busy) break;
        end
        chk("free_stop_busy", int'(busy), 0);
        chk("free_stop_waddr", int'(write_addr), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
